regfile_wb_arbiter: RTL and testbench

//  Shares the single 32x32 register-file write port among N_REQ writeback requesters
//  (e.g. ALU result, load data, multi-cycle mul/div). Arbitrates round-robin with a

---
 rtl/regfile_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among N_REQ
// writeback sources; registers the winner onto WE/Wadr/Wdata and counts stalls.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [5*N_REQ-1:0]   req_adr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 WE,
  output logic [4:0]           Wadr,
  output logic [31:0]          Wdata,
  output logic                 wb_busy,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned PTR_W  = (N_REQ > 2) ? 2 : 1;
  localparam int unsigned ADR_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [ADR_W-1:0]    wadr_q, wadr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic [N_REQ-1:0]    grant_c;
  logic [N_REQ-1:0]    lo_grant_c;
  logic [PTR_W-1:0]    gidx_c;
  logic [PTR_W-1:0]    lo_idx_c;
  logic                found_hi_c;
  logic                found_lo_c;
  logic [ADR_W-1:0]    sel_adr_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                accept_c;
  logic                stall_c;

  // Round-robin pick: first valid at or above rr_ptr, else first valid from index 0.
  always_comb begin
    grant_c    = '0;
    lo_grant_c = '0;
    gidx_c     = '0;
    lo_idx_c   = '0;
    found_hi_c = 1'b0;
    found_lo_c = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid[i] && !found_lo_c) begin
        found_lo_c    = 1'b1;
        lo_grant_c[i] = 1'b1;
        lo_idx_c      = PTR_W'(i);
      end
      if (req_valid[i] && (i >= int'(rr_ptr_q)) && !found_hi_c) begin
        found_hi_c = 1'b1;
        grant_c[i] = 1'b1;
        gidx_c     = PTR_W'(i);
      end
    end
    if (!found_hi_c) begin
      grant_c = lo_grant_c;
      gidx_c  = lo_idx_c;
    end
  end

  // Winner's payload mux.
  always_comb begin
    sel_adr_c  = '0;
    sel_data_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_c[i]) begin
        sel_adr_c  = req_adr[ADR_W*i +: ADR_W];
        sel_data_c = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Grant is combinational but suppressed while reset is asserted.
  assign req_ready = RST ? '0 : grant_c;
  assign accept_c  = |req_ready;
  assign stall_c   = |(req_valid & ~req_ready);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    we_d        = 1'b0;
    wadr_d      = wadr_q;
    wdata_d     = wdata_q;
    stall_cnt_d = stall_cnt_q;

    if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE:    state_d = accept_c ? WRITE : IDLE;
      WRITE:   state_d = accept_c ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      wadr_d   = sel_adr_c;
      wdata_d  = sel_data_c;
      // Writes to r0 are consumed but never reach the register file.
      we_d     = (sel_adr_c != '0);
      rr_ptr_d = (gidx_c == PTR_W'(N_REQ - 1)) ? '0 : gidx_c + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      we_q        <= 1'b0;
      wadr_q      <= '0;
      wdata_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      wadr_q      <= wadr_d;
      wdata_q     <= wdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign WE        = we_q;
  assign Wadr      = wadr_q;
  assign Wdata     = wdata_q;
  assign wb_busy   = (state_q == WRITE);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: main instance (N_REQ=2, CNT_W=16) plus a
// CNT_W=4 instance for counter saturation; a small register-file model sits on the write port.
module tb_regfile_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic [1:0]  req_valid;
  logic [9:0]  req_adr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        WE;
  logic [4:0]  Wadr;
  logic [31:0] Wdata;
  logic        wb_busy;
  logic [15:0] stall_cnt;

  logic [1:0]  s_valid;
  logic [9:0]  s_adr;
  logic [63:0] s_data;
  logic [1:0]  s_ready;
  logic        s_we;
  logic [4:0]  s_wadr;
  logic [31:0] s_wdata;
  logic        s_busy;
  logic [3:0]  s_stall;

  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.N_REQ(2), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_adr(req_adr),
    .req_data(req_data), .req_ready(req_ready), .WE(WE), .Wadr(Wadr),
    .Wdata(Wdata), .wb_busy(wb_busy), .stall_cnt(stall_cnt)
  );

  regfile_wb_arbiter #(.N_REQ(2), .CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .req_valid(s_valid), .req_adr(s_adr),
    .req_data(s_data), .req_ready(s_ready), .WE(s_we), .Wadr(s_wadr),
    .Wdata(s_wdata), .wb_busy(s_busy), .stall_cnt(s_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file behind the write port; r0 is hardwired to zero.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge CLK) if (WE && (Wadr != 5'd0)) rf[Wadr] <= Wdata;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 2'b00;
    req_adr   = '0;
    req_data  = '0;
    s_valid   = 2'b00;
    s_adr     = {5'd2, 5'd1};
    s_data    = {32'h2222_2222, 32'h1111_1111};
    tick();
    tick();

    // Reset state, with requests already pending
    req_valid = 2'b11;
    req_adr   = {5'd4, 5'd3};
    req_data  = {32'hA1A1_A1A1, 32'hA0A0_A0A0};
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(WE), 32'h0);
    chk("rst_busy", 32'(wb_busy), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_wadr", 32'(Wadr), 32'h0);

    // Contention from reset: grants 0,1,0, one stall per cycle
    RST = 1'b0;
    #1;
    chk("cont_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("cont_we1", 32'(WE), 32'h1);
    chk("cont_wadr1", 32'(Wadr), 32'h3);
    chk("cont_wdata1", Wdata, 32'hA0A0_A0A0);
    chk("cont_busy1", 32'(wb_busy), 32'h1);
    chk("cont_stall1", 32'(stall_cnt), 32'h1);
    chk("cont_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("cont_wadr2", 32'(Wadr), 32'h4);
    chk("cont_wdata2", Wdata, 32'hA1A1_A1A1);
    chk("cont_stall2", 32'(stall_cnt), 32'h2);
    chk("cont_ready2", 32'(req_ready), 32'h1);
    tick();
    chk("cont_wadr3", 32'(Wadr), 32'h3);
    chk("cont_stall3", 32'(stall_cnt), 32'h3);
    chk("cont_ready3", 32'(req_ready), 32'h2);
    req_valid = 2'b00;
    tick();
    chk("idle_we", 32'(WE), 32'h0);
    chk("idle_busy", 32'(wb_busy), 32'h0);
    chk("idle_wadr_hold", 32'(Wadr), 32'h3);
    chk("idle_stall_hold", 32'(stall_cnt), 32'h3);
    chk("rf3", rf[3], 32'hA0A0_A0A0);
    chk("rf4", rf[4], 32'hA1A1_A1A1);

    // Single request; pointer sits at 1 so the search wraps to 0
    req_valid = 2'b01;
    req_adr   = {5'd0, 5'd5};
    req_data  = {32'h0, 32'hDEAD_BEEF};
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_we", 32'(WE), 32'h1);
    chk("single_wadr", 32'(Wadr), 32'h5);
    chk("single_wdata", Wdata, 32'hDEAD_BEEF);
    req_valid = 2'b00;
    tick();
    chk("single_rf5", rf[5], 32'hDEAD_BEEF);
    chk("single_stall", 32'(stall_cnt), 32'h3);

    // Address 0 from requester 1: consumed, busy, no write enable
    req_valid = 2'b10;
    req_adr   = {5'd0, 5'd0};
    req_data  = {32'h0000_1234, 32'h0};
    #1;
    chk("a0_ready", 32'(req_ready), 32'h2);
    tick();
    chk("a0_we", 32'(WE), 32'h0);
    chk("a0_busy", 32'(wb_busy), 32'h1);
    chk("a0_wdata", Wdata, 32'h0000_1234);
    req_valid = 2'b00;
    tick();
    chk("a0_rf0", rf[0], 32'h0);
    chk("a0_busy_off", 32'(wb_busy), 32'h0);

    // Same address from both requesters, pointer at 0: later grant wins
    req_valid = 2'b11;
    req_adr   = {5'd7, 5'd7};
    req_data  = {32'h2, 32'h1};
    #1;
    chk("same_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("same_wdata0", Wdata, 32'h1);
    chk("same_stall0", 32'(stall_cnt), 32'h4);
    req_valid = 2'b10;
    #1;
    chk("same_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("same_rf7_first", rf[7], 32'h1);
    chk("same_wdata1", Wdata, 32'h2);
    req_valid = 2'b00;
    tick();
    chk("same_rf7_second", rf[7], 32'h2);
    chk("same_stall1", 32'(stall_cnt), 32'h4);

    // Reset mid-write: pointer is moved to 1 first, then reset drops the write
    req_valid = 2'b01;
    req_adr   = {5'd0, 5'd9};
    req_data  = {32'h0, 32'h0000_0055};
    tick();
    chk("mid_we_pre", 32'(WE), 32'h1);
    RST = 1'b1;
    #1;
    chk("mid_we", 32'(WE), 32'h0);
    chk("mid_busy", 32'(wb_busy), 32'h0);
    chk("mid_stall", 32'(stall_cnt), 32'h0);
    chk("mid_ready", 32'(req_ready), 32'h0);
    tick();
    chk("mid_rf9", rf[9], 32'h0);
    req_valid = 2'b11;
    RST = 1'b0;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    tick();

    // Saturation on the 4-bit counter with two requests held 20 cycles
    s_valid = 2'b11;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(s_stall), 32'hE);
    tick();
    chk("sat_15", 32'(s_stall), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 32'(s_stall), 32'hF);
    s_valid = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
